// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle MIPS multiply/divide unit with architectural HI/LO registers
//   clk   in  clock, rising edge
//   clrn  in  asynchronous active-high reset
//   start in  request, accepted only while busy==0
//   op    in  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   a, b  in  operands rs / rt
//   busy  out unit occupied (stall request)
//   done  out one-cycle pulse in the first cycle hi/lo hold a new MUL/DIV result
//   hi,lo out HI/LO registers
//   FAST_MUL_EN: when defined, MULT/MULTU complete in one cycle via a combinational multiplier
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state, state_n;
    logic [2*WIDTH-1:0] p, p_step, p_load, res;
    logic [WIDTH-1:0]   m, am, bm;
    logic [WIDTH:0]     add_s, rem_t, sub_s;
    logic [CNT_W-1:0]   cnt;
    logic               is_div, sa, sb, go, sgn, fast;
    assign sgn  = ~op[0];
    assign go   = start & (state == IDLE) & ~op[2];
    assign am   = (sgn & a[WIDTH-1]) ? -a : a;
    assign bm   = (sgn & b[WIDTH-1]) ? -b : b;
    assign busy = state != IDLE;
`ifdef FAST_MUL_EN
    assign fast   = ~op[1];
    assign p_load = op[1] ? {{WIDTH{1'b0}}, am} : {{WIDTH{1'b0}}, am} * {{WIDTH{1'b0}}, bm};
`else
    assign fast   = 1'b0;
    assign p_load = {{WIDTH{1'b0}}, op[1] ? am : bm};
`endif
    // Multiply keeps the multiplier in p's low half and shifts the product in from the top;
    // divide keeps the dividend in the low half and shifts quotient bits in from the bottom.
    always_comb begin
        add_s  = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
        rem_t  = p[2*WIDTH-1:WIDTH-1];
        sub_s  = rem_t - {1'b0, m};
        p_step = is_div ? (sub_s[WIDTH] ? {rem_t[WIDTH-1:0], p[WIDTH-2:0], 1'b0}
                                        : {sub_s[WIDTH-1:0], p[WIDTH-2:0], 1'b1})
                        : {add_s, p[WIDTH-1:1]};
        // A zero divisor leaves quotient all-ones uncorrected; the remainder correction
        // then restores the dividend exactly as presented.
        res    = is_div ? {sa ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH],
                           ((sa ^ sb) && m != '0) ? -p[WIDTH-1:0] : p[WIDTH-1:0]}
                        : ((sa ^ sb) ? -p : p);
    end
    always_comb begin
        state_n = state == IDLE ? (go ? (fast ? FIX : RUN) : IDLE)
                : state == RUN  ? (cnt == CNT_W'(WIDTH-1) ? FIX : RUN)
                : IDLE;
    end
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) state <= IDLE;
        else      state <= state_n;
    end
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            p      <= '0;
            m      <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= state == FIX;
            if (state == IDLE) begin
                if (start && op == 3'b100) hi <= a;
                if (start && op == 3'b101) lo <= a;
                if (go) begin
                    p      <= p_load;
                    m      <= op[1] ? bm : am;
                    cnt    <= '0;
                    is_div <= op[1];
                    sa     <= sgn & a[WIDTH-1];
                    sb     <= sgn & b[WIDTH-1];
                end
            end else if (state == RUN) begin
                p   <= p_step;
                cnt <= cnt + 1'b1;
            end else begin
                {hi, lo} <= res;
            end
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: randomized and directed self-checking bench for mul_div_unit
module tb_mul_div_unit;
    logic        clk = 1'b0, clrn, start, busy, done;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    int pass_cnt = 0, fail_cnt = 0;
    always #5 clk = ~clk;
    mul_div_unit dut (.clk(clk), .clrn(clrn), .start(start), .op(op), .a(a), .b(b),
                      .busy(busy), .done(done), .hi(hi), .lo(lo));
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assert (got === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (o)
            3'd0: return 64'(sx * sy);
            3'd1: return ux * uy;
            3'd2, 3'd3: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                q = (o == 3'd2) ? sx / sy : longint'(ux / uy);
                r = (o == 3'd2) ? sx % sy : longint'(ux % uy);
                return {r[31:0], q[31:0]};
            end
            default: return 64'b0;
        endcase
    endfunction
    function automatic int latency(input logic [2:0] o);
`ifdef FAST_MUL_EN
        return o[1] ? 33 : 1;
`else
        return 33;
`endif
    endfunction
    task automatic finish_op(input string tag, input logic [63:0] e, input int lat);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({tag, " busy cycles"}, 64'(n), 64'(lat));
        check({tag, " hi:lo"}, {hi, lo}, e);
        check({tag, " done pulse"}, 64'(done), 64'd1);
        @(negedge clk);
        check({tag, " done clears"}, 64'(done), 64'd0);
    endtask
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        finish_op(tag, model(o, x, y), latency(o));
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        logic [2:0] o;
        logic [31:0] x, y;
        clrn = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi:lo", {hi, lo}, 64'd0);
        clrn = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 3'b100; a = 32'h12345678;
        @(negedge clk);
        start = 1'b0;
        check("mthi hi:lo", {hi, lo}, {32'h12345678, 32'h0});
        check("mthi busy", 64'(busy), 64'd0);
        check("mthi done", 64'(done), 64'd0);
        @(negedge clk);
        check("mthi busy later", 64'(busy), 64'd0);
        check("mthi done later", 64'(done), 64'd0);
        start = 1'b1; op = 3'b110; a = 32'h55555555; b = 32'h0;
        @(negedge clk);
        start = 1'b0;
        check("noop busy", 64'(busy), 64'd0);
        check("noop hi:lo", {hi, lo}, {32'h12345678, 32'h0});
        start = 1'b1; op = 3'b101; a = 32'hCAFEBABE;
        @(negedge clk);
        start = 1'b0;
        check("mtlo hi:lo", {hi, lo}, {32'h12345678, 32'hCAFEBABE});
        run_op("multu max", 3'd1, 32'hFFFFFFFF, 32'h2);
        run_op("mult neg", 3'd0, 32'hFFFFFFFD, 32'd7);
        run_op("div neg", 3'd2, 32'hFFFFFFF9, 32'd2);
        run_op("divu zero", 3'd3, 32'd7, 32'd0);
        run_op("div zero neg", 3'd2, 32'hFFFFFFF9, 32'd0);
        run_op("div overflow", 3'd2, 32'h80000000, 32'hFFFFFFFF);
        run_op("multu 2^32", 3'd1, 32'h00010000, 32'h00010000);
        run_op("mult minneg", 3'd0, 32'h80000000, 32'h80000000);
        run_op("div rem sign", 3'd2, 32'd7, 32'hFFFFFFFE);
        for (int i = 0; i < 24; i++) begin
            o = 3'($urandom_range(0, 3));
            x = $urandom;
            y = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) != 0 ? $urandom : 32'($urandom_range(1, 100)));
            run_op($sformatf("rand%0d op%0d", i, o), o, x, y);
        end
        @(negedge clk);
        start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 3'b101; a = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0;
        finish_op("divu mtlo busy", {32'd2, 32'd14}, 33 - 5);
        @(negedge clk);
        start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 clrn = 1'b1;
        #1;
        check("clrn busy", 64'(busy), 64'd0);
        check("clrn hi:lo", {hi, lo}, 64'd0);
        #1 clrn = 1'b0;
        start = 1'b1; op = 3'b001; a = 32'd3; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        finish_op("after clrn", 64'd15, latency(3'b001));
        $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
        $finish;
    end
endmodule
